// File: rtl/food_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | food_map                                                                 |
// | Per-cell food store with render-side tile addressing and eat/place port. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module food_map #(
  parameter int         GRID_W    = 40,
  parameter int         GRID_H    = 30,
  parameter logic [1:0] INIT_TYPE = 2'd1,
  parameter int         SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         px_x,
  input  logic [9:0]         px_y,
  input  logic               px_valid,
  output logic [3:0]         tile_x,
  output logic [3:0]         tile_y,
  output logic [1:0]         food_type,
  output logic               tile_valid,
  input  logic               eat_req,
  input  logic               place_req,
  input  logic [5:0]         cmd_cx,
  input  logic [4:0]         cmd_cy,
  input  logic [1:0]         place_type,
  output logic               eat_ack,
  output logic               place_ack,
  output logic [1:0]         eaten_type,
  output logic               busy,
  output logic [10:0]        food_left,
  output logic [SCORE_W-1:0] score,
  output logic               all_eaten
);

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int ADDR_W = $clog2(CELLS);

  localparam logic [5:0]        C_GRID_W6   = 6'(GRID_W);
  localparam logic [5:0]        C_GRID_H6   = 6'(GRID_H);
  localparam logic [5:0]        C_LAST_X    = 6'(GRID_W - 1);
  localparam logic [5:0]        C_LAST_Y    = 6'(GRID_H - 1);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(CELLS - 1);

  typedef enum logic [0:0] {INIT, RUN} state_e;
  typedef enum logic [1:0] {CIDLE, CREAD, CWRITE} cstate_e;

  state_e  state_q, state_d;
  cstate_e cstate_q, cstate_d;

  logic [1:0] mem_q [CELLS];

  logic [ADDR_W-1:0]  init_addr_q, init_addr_d;
  logic [5:0]         init_cx_q, init_cx_d;
  logic [4:0]         init_cy_q, init_cy_d;
  logic [10:0]        food_left_q, food_left_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         eaten_type_q, eaten_type_d;
  logic               op_eat_q, op_eat_d;
  logic [5:0]         cx_q, cx_d;
  logic [4:0]         cy_q, cy_d;
  logic [1:0]         ptype_q, ptype_d;
  logic [1:0]         old_q, old_d;
  logic               tile_valid_q, tile_valid_d;
  logic [3:0]         tile_x_q, tile_x_d;
  logic [3:0]         tile_y_q, tile_y_d;
  logic [1:0]         food_type_q, food_type_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [1:0]        mem_wdata;

  logic [5:0]         w_rx, w_ry;
  logic               w_rin, w_cin, w_border;
  logic [ADDR_W-1:0]  w_raddr, w_caddr;
  logic [1:0]         w_new, w_init_data;
  logic [SCORE_W:0]   w_sum;

  assign w_rx  = px_x[9:4];
  assign w_ry  = px_y[9:4];
  assign w_rin = (w_rx < C_GRID_W6) && (w_ry < C_GRID_H6);
  assign w_cin = (cx_q < C_GRID_W6) && ({1'b0, cy_q} < C_GRID_H6);

  // Out-of-grid coordinates are steered to address 0 so the array is never over-indexed.
  assign w_raddr = w_rin ? (ADDR_W'(w_ry) * ADDR_W'(GRID_W) + ADDR_W'(w_rx)) : '0;
  assign w_caddr = w_cin ? (ADDR_W'(cy_q) * ADDR_W'(GRID_W) + ADDR_W'(cx_q)) : '0;

  assign w_border = (init_cx_q == 6'd0) || (init_cx_q == C_LAST_X) ||
                    (init_cy_q == 5'd0) || ({1'b0, init_cy_q} == C_LAST_Y);
  assign w_init_data = w_border ? 2'd0 : INIT_TYPE;
  assign w_new       = (ptype_q == 2'd3) ? 2'd0 : ptype_q;
  assign w_sum       = {1'b0, score_q} +
                       ((old_q == 2'd2) ? (SCORE_W+1)'(5) : (SCORE_W+1)'(1));

  always_comb begin
    state_d      = state_q;
    cstate_d     = cstate_q;
    init_addr_d  = init_addr_q;
    init_cx_d    = init_cx_q;
    init_cy_d    = init_cy_q;
    food_left_d  = food_left_q;
    score_d      = score_q;
    eaten_type_d = eaten_type_q;
    op_eat_d     = op_eat_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    ptype_d      = ptype_q;
    old_d        = old_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = 2'd0;
    eat_ack      = 1'b0;
    place_ack    = 1'b0;

    tile_valid_d = px_valid;
    tile_x_d     = px_x[3:0];
    tile_y_d     = px_y[3:0];
    food_type_d  = 2'd0;
    if (px_valid && w_rin && (state_q == RUN)) begin
      food_type_d = mem_q[w_raddr];
    end

    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_addr_q;
        mem_wdata = w_init_data;
        if (w_init_data != 2'd0) begin
          food_left_d = food_left_q + 11'd1;
        end
        if (init_cx_q == C_LAST_X) begin
          init_cx_d = 6'd0;
          init_cy_d = init_cy_q + 5'd1;
        end else begin
          init_cx_d = init_cx_q + 6'd1;
        end
        init_addr_d = init_addr_q + ADDR_W'(1);
        if (init_addr_q == C_LAST_ADDR) begin
          state_d = RUN;
        end
      end

      RUN: begin
        case (cstate_q)
          CIDLE: begin
            if (eat_req || place_req) begin
              op_eat_d = eat_req;
              cx_d     = cmd_cx;
              cy_d     = cmd_cy;
              ptype_d  = place_type;
              cstate_d = CREAD;
            end
          end

          CREAD: begin
            old_d = w_cin ? mem_q[w_caddr] : 2'd0;
            // Latched one cycle early so eaten_type is already valid alongside eat_ack.
            if (op_eat_q) begin
              eaten_type_d = w_cin ? mem_q[w_caddr] : 2'd0;
            end
            cstate_d = CWRITE;
          end

          CWRITE: begin
            cstate_d = CIDLE;
            if (op_eat_q) begin
              eat_ack = 1'b1;
              if (w_cin && (old_q != 2'd0)) begin
                mem_we      = 1'b1;
                mem_waddr   = w_caddr;
                mem_wdata   = 2'd0;
                food_left_d = food_left_q - 11'd1;
                score_d     = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
              end
            end else begin
              place_ack = 1'b1;
              if (w_cin) begin
                mem_we    = 1'b1;
                mem_waddr = w_caddr;
                mem_wdata = w_new;
                if ((old_q == 2'd0) && (w_new != 2'd0)) begin
                  food_left_d = food_left_q + 11'd1;
                end else if ((old_q != 2'd0) && (w_new == 2'd0)) begin
                  food_left_d = food_left_q - 11'd1;
                end
              end
            end
          end

          default: cstate_d = CIDLE;
        endcase
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      cstate_q     <= CIDLE;
      init_addr_q  <= '0;
      init_cx_q    <= 6'd0;
      init_cy_q    <= 5'd0;
      food_left_q  <= 11'd0;
      score_q      <= '0;
      eaten_type_q <= 2'd0;
      op_eat_q     <= 1'b0;
      cx_q         <= 6'd0;
      cy_q         <= 5'd0;
      ptype_q      <= 2'd0;
      old_q        <= 2'd0;
      tile_valid_q <= 1'b0;
      tile_x_q     <= 4'd0;
      tile_y_q     <= 4'd0;
      food_type_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      cstate_q     <= cstate_d;
      init_addr_q  <= init_addr_d;
      init_cx_q    <= init_cx_d;
      init_cy_q    <= init_cy_d;
      food_left_q  <= food_left_d;
      score_q      <= score_d;
      eaten_type_q <= eaten_type_d;
      op_eat_q     <= op_eat_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      ptype_q      <= ptype_d;
      old_q        <= old_d;
      tile_valid_q <= tile_valid_d;
      tile_x_q     <= tile_x_d;
      tile_y_q     <= tile_y_d;
      food_type_q  <= food_type_d;
    end
  end

  // Render reads sample the pre-write contents when a command writes the same cell.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign food_type  = food_type_q;
  assign tile_valid = tile_valid_q;
  assign eaten_type = eaten_type_q;
  assign busy       = (state_q == INIT);
  assign food_left  = food_left_q;
  assign score      = score_q;
  assign all_eaten  = (food_left_q == 11'd0) && (state_q != INIT);

endmodule
`default_nettype wire

// File: tb/tb_food_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_food_map                                                              |
// | Directed bench for food_map: init sweep, render vectors, commands.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_food_map;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  px_x, px_y;
  logic        px_valid;
  logic [3:0]  tile_x, tile_y;
  logic [1:0]  food_type;
  logic        tile_valid;
  logic        eat_req, place_req;
  logic [5:0]  cmd_cx;
  logic [4:0]  cmd_cy;
  logic [1:0]  place_type;
  logic        eat_ack, place_ack;
  logic [1:0]  eaten_type;
  logic        busy;
  logic [10:0] food_left;
  logic [15:0] score;
  logic        all_eaten;

  int checks = 0;
  int passed = 0;

  food_map dut (
    .clk(clk), .rst(rst),
    .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
    .tile_x(tile_x), .tile_y(tile_y), .food_type(food_type), .tile_valid(tile_valid),
    .eat_req(eat_req), .place_req(place_req),
    .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .place_type(place_type),
    .eat_ack(eat_ack), .place_ack(place_ack), .eaten_type(eaten_type),
    .busy(busy), .food_left(food_left), .score(score), .all_eaten(all_eaten)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic [3:0] tx;
    logic [3:0] ty;
    logic [1:0] ft;
  } rvec_t;

  rvec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Counts negedges with busy high; starts at a negedge where busy is expected high.
  task automatic wait_init(output int cnt, output int acks);
    cnt  = 0;
    acks = 0;
    while (busy && cnt < 3000) begin
      cnt++;
      if (eat_ack || place_ack) acks++;
      @(negedge clk);
    end
  endtask

  // Issues one command at a negedge; returns ack latency and eaten_type at the ack,
  // then waits one more cycle so counters have settled.
  task automatic run_cmd(input logic is_eat, input logic [5:0] cx, input logic [4:0] cy,
                         input logic [1:0] pt, output int lat, output int et);
    eat_req    = is_eat;
    place_req  = !is_eat;
    cmd_cx     = cx;
    cmd_cy     = cy;
    place_type = pt;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(is_eat ? eat_ack : place_ack) && lat < 20);
    et        = int'(eaten_type);
    eat_req   = 1'b0;
    place_req = 1'b0;
    @(negedge clk);
  endtask

  int cnt, acks, lat, et, e_at, p_at, both;

  initial begin
    vecs[0] = '{10'd16,  10'd16,  1'b1, 4'd0,  4'd0,  2'd1};
    vecs[1] = '{10'd37,  10'd250, 1'b1, 4'd5,  4'd10, 2'd1};
    vecs[2] = '{10'd0,   10'd0,   1'b1, 4'd0,  4'd0,  2'd0};
    vecs[3] = '{10'd650, 10'd10,  1'b1, 4'd10, 4'd10, 2'd0};
    vecs[4] = '{10'd21,  10'd39,  1'b0, 4'd5,  4'd7,  2'd0};
    vecs[5] = '{10'd639, 10'd479, 1'b1, 4'd15, 4'd15, 2'd0};
    vecs[6] = '{10'd623, 10'd463, 1'b1, 4'd15, 4'd15, 2'd1};
    vecs[7] = '{10'd16,  10'd480, 1'b1, 4'd0,  4'd0,  2'd0};
    vecs[8] = '{10'd100, 10'd40,  1'b1, 4'd4,  4'd8,  2'd1};

    rst = 1'b1; px_x = '0; px_y = '0; px_valid = 1'b0;
    eat_req = 1'b0; place_req = 1'b0; cmd_cx = '0; cmd_cy = '0; place_type = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_busy", int'(busy), 1);
    check("rst_food_left", int'(food_left), 0);
    check("rst_score", int'(score), 0);
    check("rst_tile_valid", int'(tile_valid), 0);
    check("rst_all_eaten", int'(all_eaten), 0);
    wait_init(cnt, acks);
    check("init_cycles", cnt, 1200);
    check("init_food_left", int'(food_left), 1064);
    check("init_all_eaten", int'(all_eaten), 0);
    check("init_score", int'(score), 0);

    for (int i = 0; i < 9; i++) begin
      px_x = vecs[i].x; px_y = vecs[i].y; px_valid = vecs[i].v;
      @(negedge clk);
      check($sformatf("render%0d_valid", i), int'(tile_valid), int'(vecs[i].v));
      check($sformatf("render%0d_tx", i), int'(tile_x), int'(vecs[i].tx));
      check($sformatf("render%0d_ty", i), int'(tile_y), int'(vecs[i].ty));
      check($sformatf("render%0d_type", i), int'(food_type), int'(vecs[i].ft));
    end
    px_valid = 1'b0;

    run_cmd(1'b1, 6'd5, 5'd5, 2'd0, lat, et);
    check("eat1_lat", lat, 2);
    check("eat1_type", et, 1);
    check("eat1_score", int'(score), 1);
    check("eat1_left", int'(food_left), 1063);

    run_cmd(1'b1, 6'd5, 5'd5, 2'd0, lat, et);
    check("eat2_lat", lat, 2);
    check("eat2_type", et, 0);
    check("eat2_score", int'(score), 1);
    check("eat2_left", int'(food_left), 1063);

    run_cmd(1'b0, 6'd5, 5'd5, 2'd2, lat, et);
    check("place1_lat", lat, 2);
    check("place1_left", int'(food_left), 1064);

    run_cmd(1'b1, 6'd5, 5'd5, 2'd0, lat, et);
    check("eat3_type", et, 2);
    check("eat3_score", int'(score), 6);
    check("eat3_left", int'(food_left), 1063);

    run_cmd(1'b0, 6'd6, 5'd6, 2'd3, lat, et);
    check("place3_left", int'(food_left), 1062);
    check("place3_eaten_kept", int'(eaten_type), 2);
    px_x = 10'd96; px_y = 10'd96; px_valid = 1'b1;
    @(negedge clk);
    check("place3_cell", int'(food_type), 0);

    run_cmd(1'b0, 6'd0, 5'd0, 2'd1, lat, et);
    check("place_border_left", int'(food_left), 1063);
    px_x = 10'd0; px_y = 10'd0;
    @(negedge clk);
    check("place_border_cell", int'(food_type), 1);
    px_valid = 1'b0;

    run_cmd(1'b1, 6'd45, 5'd3, 2'd0, lat, et);
    check("oog_eat_lat", lat, 2);
    check("oog_eat_type", et, 0);
    check("oog_eat_left", int'(food_left), 1063);
    run_cmd(1'b0, 6'd3, 5'd30, 2'd2, lat, et);
    check("oog_place_lat", lat, 2);
    check("oog_place_left", int'(food_left), 1063);

    // Simultaneous requests: eat served first, place re-accepted afterwards.
    eat_req = 1'b1; place_req = 1'b1; cmd_cx = 6'd10; cmd_cy = 5'd10; place_type = 2'd2;
    e_at = -1; p_at = -1; both = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (eat_ack && place_ack) both = 1;
      if (eat_ack && e_at < 0) begin e_at = k; eat_req = 1'b0; end
      if (place_ack && p_at < 0) begin p_at = k; place_req = 1'b0; end
    end
    check("both_eat_at", e_at, 2);
    check("both_place_at", p_at, 5);
    check("both_overlap", both, 0);
    check("both_score", int'(score), 7);
    check("both_left", int'(food_left), 1063);

    // Render of the cell being written returns the old value.
    eat_req = 1'b1; cmd_cx = 6'd20; cmd_cy = 5'd20;
    @(negedge clk);
    @(negedge clk);
    check("rdw_ack", int'(eat_ack), 1);
    eat_req = 1'b0; px_x = 10'd320; px_y = 10'd320; px_valid = 1'b1;
    @(negedge clk);
    check("rdw_old", int'(food_type), 1);
    @(negedge clk);
    check("rdw_new", int'(food_type), 0);
    px_valid = 1'b0;
    check("rdw_score", int'(score), 8);
    check("rdw_left", int'(food_left), 1062);

    // Reset during CREAD, with the request left asserted across the re-init.
    eat_req = 1'b1; cmd_cx = 6'd21; cmd_cy = 5'd21;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ack", int'(eat_ack), 0);
    check("mid_rst_busy", int'(busy), 1);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_left", int'(food_left), 0);
    wait_init(cnt, acks);
    check("reinit_cycles", cnt, 1200);
    check("reinit_acks", acks, 0);
    check("reinit_left", int'(food_left), 1064);
    lat = 0;
    while (!eat_ack && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("held_lat", lat, 2);
    check("held_type", int'(eaten_type), 1);
    eat_req = 1'b0;
    @(negedge clk);
    check("held_score", int'(score), 1);
    check("held_left", int'(food_left), 1063);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/food_map.md
Name: food_map

Overview:
- Food-state store and tile-addressing stage sitting directly upstream of the per-tile food sprite lookup.
- Holds a 2-bit food type per 16x16 maze cell.
- Render side: converts the pixel scan position into a cell-local pixel offset (x, y) plus that cell's food type, ready for the sprite lookup.
- Command side: serves eat/place requests from game logic and keeps a remaining-food count and a score.

Parameters:
- GRID_W, 40, maze width in cells.
- GRID_H, 30, maze height in cells.
- INIT_TYPE, 1, food type loaded into every non-border cell at init.
- SCORE_W, 16, score counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- px_x  in  10  screen pixel x.
- px_y  in  10  screen pixel y.
- px_valid  in  1  px_x/px_y valid this cycle.
- tile_x  out  4  pixel x within cell (to sprite lookup).
- tile_y  out  4  pixel y within cell.
- food_type  out  2  food type of addressed cell.
- tile_valid  out  1  tile_x/tile_y/food_type valid.
- eat_req  in  1  eat request, level, held until eat_ack.
- place_req  in  1  place request, level, held until place_ack.
- cmd_cx  in  6  command cell column.
- cmd_cy  in  5  command cell row.
- place_type  in  2  type to place.
- eat_ack  out  1  one-cycle eat completion pulse.
- place_ack  out  1  one-cycle place completion pulse.
- eaten_type  out  2  type removed by the acked eat; 0 = nothing there.
- busy  out  1  init sweep in progress.
- food_left  out  11  number of cells with nonzero type.
- score  out  SCORE_W  accumulated score.
- all_eaten  out  1  food_left==0 and not busy.

Behaviour:
- Storage: GRID_W*GRID_H x 2-bit, address = cy*GRID_W+cx; one read port (render) and one read/write port (commands).
- Main FSM INIT/RUN. rst (any state, any time) -> INIT, init counter 0, score 0, food_left 0, all outputs 0, busy 1; any in-flight command is dropped with no ack.
- INIT:
  - One cell written per cycle in address order.
  - Border cells (cx==0, cx==GRID_W-1, cy==0, cy==GRID_H-1) get 0; all others get INIT_TYPE.
  - food_left increments per nonzero write.
  - After the last cell (GRID_W*GRID_H cycles), go to RUN and set busy=0.
- Render pipe, latency 1:
  - Registered on every cycle: tile_valid<=px_valid, tile_x<=px_x[3:0], tile_y<=px_y[3:0].
  - food_type<=stored type of cell (px_x>>4, px_y>>4).
  - Forced to 0 if the cell is outside the grid, if busy, or if px_valid=0.
- Command FSM CIDLE/CREAD/CWRITE, active only in RUN:
  - CIDLE: accept eat_req, else place_req (eat wins when both are high); latch cmd_cx/cmd_cy/place_type -> CREAD.
  - CREAD: read the cell -> CWRITE.
  - CWRITE: update the cell and counters, pulse the matching ack for exactly 1 cycle -> CIDLE. The next acceptance is no earlier than the following cycle.
  - Ack timing: accepted at cycle N -> ack at N+2.
- Eat in CWRITE:
  - eaten_type = old type.
  - If old nonzero: write 0, food_left-1, score += 1 (type 1) or 5 (type 2).
  - score saturates at all-ones.
- Place in CWRITE:
  - place_type 3 is treated as 0.
  - Write the new type.
  - food_left +1 if old==0 and new!=0; -1 if old!=0 and new==0; otherwise unchanged.
  - eaten_type unchanged.
- Out-of-grid command cell: no write, no counter change; still acked at N+2 with eaten_type 0.
- Stored type 3 never exists.
- Requests present during INIT are held until RUN.
- A render read of the cell being written in CWRITE returns the old value.

Test Plan:
- rst 1 cycle -> busy=1 for exactly 1200 cycles, then food_left=1064 (38*28), all_eaten=0, score=0.
- RUN, px (16,16) valid -> next cycle tile_x=0, tile_y=0, food_type=1; px (37,250) -> tile_x=5, tile_y=10, type 1; px (0,0) -> type 0; px (650,10) -> type 0; px_valid=0 -> tile_valid=0, type 0.
- eat (5,5) -> eat_ack 2 cycles after acceptance, eaten_type=1, score=1, food_left=1063; repeat -> eaten_type=0, score/food_left unchanged.
- place (5,5) type 2 -> place_ack, food_left=1064; eat (5,5) -> eaten_type=2, score=6; place type 3 at (6,6) -> cell 0, food_left-1.
- eat_req and place_req both high at N -> eat_ack at N+2, place_ack at N+5, never both in one cycle.
- Assert rst at the CREAD cycle of an eat -> no eat_ack, busy=1, score=0, full 1200-cycle INIT repeats.
